// File: rtl/sevensegment_bcd_capture.sv
// Seven-segment bus capture: filters each multiplexed digit for stability,
// decodes it back to BCD and publishes a packed frame once every digit is seen.
module sevensegment_bcd_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int         TW      = DIGITS + 7;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  // Returns {illegal, code}; blank maps to 4'hF, anything unknown to 4'hE.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b0000000: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  logic [TW-1:0]         prev_q, prev_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [DIGITS-1:0]     err_q, err_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;

  logic [6:0]            seg;
  logic [TW-1:0]         tuple;
  logic                  tuple_ok;
  logic                  same;
  logic                  capture;
  logic [4:0]            dec;

  always_comb begin
    seg           = {a, b, c, d, e, f, g};
    tuple         = {dig_en, seg};
    tuple_ok      = $onehot(dig_en);
    same          = (tuple == prev_q);
    dec           = decode(seg);
    prev_d        = tuple;
    cnt_d         = 4'd0;
    captured_d    = same ? captured_q : 1'b0;
    mask_d        = mask_q;
    err_d         = err_q;
    shadow_d      = shadow_q;
    bcd_out_d     = bcd_out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = frame_err_q;

    if (tuple_ok && same)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;

    // The counter saturates, so the captured flag is what limits a run to one capture.
    capture = tuple_ok && same && !captured_q && (cnt_d == CNT_MAX);

    if (capture) begin
      captured_d = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_en[i]) begin
          shadow_d[4*i +: 4] = dec[3:0];
          err_d[i]           = dec[4];
          mask_d[i]          = 1'b1;
        end
      end
      if (&mask_d) begin
        bcd_out_d     = shadow_d;
        frame_valid_d = 1'b1;
        frame_err_d   = |err_d;
        mask_d        = '0;
        err_d         = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q        <= '0;
      cnt_q         <= 4'd0;
      captured_q    <= 1'b0;
      mask_q        <= '0;
      err_q         <= '0;
      shadow_q      <= '0;
      bcd_out_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      mask_q        <= mask_d;
      err_q         <= err_d;
      shadow_q      <= shadow_d;
      bcd_out_q     <= bcd_out_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sevensegment_bcd_capture.sv
// Directed bench for sevensegment_bcd_capture: hand-computed frames, checked
// with immediate assertions one clock step after each active edge.
module tb_sevensegment_bcd_capture;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011, PB = 7'b0000000, PX = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        frame_err;

  int          checks = 0;
  int          errors = 0;
  int          fv_count;
  logic        fv_last;
  logic [15:0] last_bcd;
  logic        last_err;

  sevensegment_bcd_capture #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dig_en(dig_en), .bcd_out(bcd_out),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one tuple for n edges, recording any frame pulses seen.
  task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
    dig_en = en;
    {a, b, c, d, e, f, g} = seg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      fv_last = frame_valid;
      if (frame_valid) begin
        fv_count++;
        last_bcd = bcd_out;
        last_err = frame_err;
      end
    end
  endtask

  task automatic clear_stats();
    fv_count = 0;
    fv_last  = 1'b0;
    last_bcd = 16'hxxxx;
    last_err = 1'bx;
  endtask

  initial begin
    rst = 1'b1;
    dig_en = 4'b0000;
    {a, b, c, d, e, f, g} = 7'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;

    // 1: basic frame 1,2,3,4
    clear_stats();
    hold(4'b0001, P1, 3);
    hold(4'b0010, P2, 3);
    hold(4'b0100, P3, 3);
    hold(4'b1000, P4, 3);
    check("t1_fv_count", 32'(fv_count), 32'd1);
    check("t1_fv_at_12th_edge", 32'(fv_last), 32'd1);
    check("t1_bcd", 32'(last_bcd), 32'h4321);
    check("t1_err", 32'(last_err), 32'd0);
    hold(4'b0000, PB, 1);
    check("t1_fv_one_cycle", 32'(frame_valid), 32'd0);

    // 2: digit 2 held too briefly is not captured
    clear_stats();
    hold(4'b0100, P0, 2);
    hold(4'b1000, P7, 3);
    hold(4'b0001, P0, 3);
    hold(4'b0010, P6, 3);
    check("t2_no_frame_without_d2", 32'(fv_count), 32'd0);
    hold(4'b0100, P5, 3);
    check("t2_fv_count", 32'(fv_count), 32'd1);
    check("t2_bcd", 32'(last_bcd), 32'h7560);

    // 3: illegal pattern flags the frame; the next clean frame does not
    clear_stats();
    hold(4'b0001, P2, 3);
    hold(4'b0010, PX, 3);
    hold(4'b0100, P3, 3);
    hold(4'b1000, P9, 3);
    check("t3_fv_count", 32'(fv_count), 32'd1);
    check("t3_bcd", 32'(last_bcd), 32'h93E2);
    check("t3_err", 32'(last_err), 32'd1);
    hold(4'b0000, PB, 1);
    check("t3_err_held", 32'(frame_err), 32'd1);
    clear_stats();
    hold(4'b0001, P1, 3);
    hold(4'b0010, P2, 3);
    hold(4'b0100, P3, 3);
    hold(4'b1000, P4, 3);
    check("t3_clean_bcd", 32'(last_bcd), 32'h4321);
    check("t3_clean_err", 32'(last_err), 32'd0);

    // 4: multi-hot enable never captures
    clear_stats();
    hold(4'b0101, P8, 10);
    hold(4'b0001, P8, 3);
    hold(4'b0010, P8, 3);
    check("t4_no_early_frame", 32'(fv_count), 32'd0);
    hold(4'b0100, P8, 3);
    check("t4_no_frame_3_digits", 32'(fv_count), 32'd0);
    hold(4'b1000, P8, 3);
    check("t4_fv_count", 32'(fv_count), 32'd1);
    check("t4_bcd", 32'(last_bcd), 32'h8888);

    // 5: reset mid-frame discards the partial frame
    clear_stats();
    hold(4'b0001, P1, 3);
    hold(4'b0010, P2, 3);
    rst = 1'b1;
    hold(4'b0000, PB, 1);
    rst = 1'b0;
    check("t5_rst_bcd", 32'(bcd_out), 32'h0);
    check("t5_rst_fv", 32'(frame_valid), 32'h0);
    check("t5_rst_ferr", 32'(frame_err), 32'h0);
    hold(4'b0100, P3, 3);
    hold(4'b1000, P4, 3);
    check("t5_no_frame", 32'(fv_count), 32'd0);
    check("t5_bcd_still_reset", 32'(bcd_out), 32'h0);
    hold(4'b0001, P5, 3);
    hold(4'b0010, P6, 3);
    check("t5_fv_count", 32'(fv_count), 32'd1);
    check("t5_bcd", 32'(last_bcd), 32'h4365);

    // 6: long blank hold captures once
    clear_stats();
    hold(4'b0001, PB, 20);
    hold(4'b0010, P9, 3);
    hold(4'b0100, P9, 3);
    check("t6_no_early_frame", 32'(fv_count), 32'd0);
    hold(4'b1000, P9, 3);
    check("t6_fv_count", 32'(fv_count), 32'd1);
    check("t6_bcd", 32'(last_bcd), 32'h999F);
    check("t6_err", 32'(last_err), 32'd0);

    // 7: recapture of a digit before completion, latest wins
    clear_stats();
    hold(4'b0001, P1, 3);
    hold(4'b0001, P7, 3);
    hold(4'b0010, P3, 3);
    hold(4'b0100, P5, 3);
    check("t7_no_early_frame", 32'(fv_count), 32'd0);
    hold(4'b1000, P0, 3);
    check("t7_fv_count", 32'(fv_count), 32'd1);
    check("t7_bcd", 32'(last_bcd), 32'h0537);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevensegment_bcd_capture.md
# sevensegment_bcd_capture

Receive-side counterpart of the BCD-to-seven-segment decoder. Samples a time-multiplexed, multi-digit seven-segment bus (segments a..g plus a one-hot digit enable) and filters each digit for stability. It decodes each segment pattern back to BCD and publishes a packed BCD frame once every digit position has been captured. Used for loopback checking of display drivers and for reading external seven-segment sources.

## Interface
- DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 3, consecutive identical samples required before capture (2..15)

- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high, sampled on clk
- dig_en  input  DIGITS  digit enable, active-high; bit i selects digit i
- bcd_out  output  4*DIGITS  packed BCD; digit i at [4i+3:4i]
- frame_valid  output  1  one-cycle pulse when bcd_out updates
- frame_err  output  1  valid with frame_valid; 1 if any digit in the frame held an illegal pattern

## Operation
- Pattern map, {a,b,c,d,e,f,g} -> code:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000000 -> 4'hF (blank), not an error
  - any other pattern -> 4'hE, error
- Sample tuple is {dig_en, a..g}. The tuple is valid only when dig_en is exactly one-hot.
- Stability counter:
  - Increments when the valid tuple equals the previous edge's tuple.
  - Resets to 0 on any tuple change, on a zero dig_en, or on a multi-hot dig_en.
  - Saturates at STABLE_CYCLES-1.
- Capture: at the STABLE_CYCLES-th consecutive edge with the same valid tuple, write the decoded code and error bit into the shadow slot of the enabled digit, and set mask[i].
- A capture occurs once per stable run. The captured flag clears only when the tuple changes.
- Recapture of a digit already in mask, before the frame completes, overwrites that shadow slot (latest wins). This is not an error.
- Frame completion: on the edge where the mask becomes all-ones (including the completing capture):
  - bcd_out <= shadow, with the completing digit's new code merged in
  - frame_valid <= 1
  - frame_err <= OR of all shadow error bits, including the completing one
  - mask and error bits <= 0
- Shadow codes are retained after a frame. Only the mask and error bits clear.

## Timing
- Reset values: bcd_out=0, frame_valid=0, frame_err=0. Internally: mask=0, counter=0, captured flag=0, shadow=0, previous-tuple register=0.
- Reset takes priority over everything on the same edge. A reset mid-frame discards the partial frame, and the next frame starts empty.
- Capture latency: a tuple first sampled at edge k is captured at edge k+STABLE_CYCLES-1.
- Output latency: bcd_out, frame_valid and frame_err update at the same edge as the completing capture. No extra pipeline stage.
- frame_valid is high for exactly one cycle per completed frame. It is never high on two consecutive cycles, because a new frame needs at least DIGITS captures.
- frame_err is held until the next frame completion. It is meaningful only when sampled with frame_valid.
- Digit order is free. Frames complete on coverage, not on sequence.
- A tuple change on the edge that would have been the capture edge restarts the count (counter <= 0). No capture occurs.
- Multi-hot or zero dig_en never captures and never corrupts the mask.

## Test plan
1. Reset, then drive digits 0..3 as patterns 1=0110000, 2=1101101, 3=1111001, 4=0110011. Hold each for 3 cycles, dig_en 0001->1000. Required: bcd_out=16'h4321, frame_valid pulses once at the 12th capture edge, frame_err=0.
2. Hold digit 2 with pattern 1111110 for only 2 cycles, then switch to digit 3. Required: no capture for digit 2, frame_valid stays 0, counter restarts.
3. Drive digit 1 with 1010101, all other digits legal. Required: frame_valid with frame_err=1 and bcd_out[7:4]=4'hE. The next clean frame reports frame_err=0.
4. Drive dig_en=0101 for 10 cycles, then a clean 4-digit frame of 8,8,8,8 (1111111). Required: multi-hot period causes no capture, then bcd_out=16'h8888.
5. Capture digits 0 and 1, assert rst for 1 cycle, then capture digits 2 and 3. Required: no frame_valid and outputs at reset values. A full frame afterward is needed for frame_valid.
6. Hold digit 0 at 0000000 for 20 cycles within a frame whose other digits are 9,9,9 (1111011). Required: single capture for digit 0, bcd_out=16'h999F, frame_err=0.
